// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and constants for the EX/MEM stage with data-cache control.
//   dc_state_e : access FSM states (idle, request strobe, waiting for completion)
//   stage_t    : fields latched by the EX/MEM stage registers
//   WordW      : datapath word width
//   DefTimeout : default WAIT-state cycle limit (optional EX_MEM_DC_TIMEOUT_EN build)
package ex_mem_pkg;

   localparam int unsigned WordW      = 16;
   localparam int unsigned DefTimeout = 255;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } dc_state_e;

   typedef struct packed {
      logic [WordW-1:0] alu;
      logic [WordW-1:0] wdata;
      logic [WordW-1:0] pc2;
      logic [2:0]       wreg;
      logic             regw;
      logic             mrd;
      logic             mwr;
      logic             mtr;
      logic             link;
      logic             halt;
      logic             dump;
      logic             err;
      logic             misalign;
   } stage_t;

endpackage

// File: rtl/dc_access_fsm.sv
// dc_access_fsm: one-shot request/done handshake with the data cache.
// Build option: EX_MEM_DC_TIMEOUT_EN adds an 8-bit WAIT-cycle counter that abandons the
// access after Timeout cycles without completion.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   start_i        : valid memory op being captured this cycle (looked at only in idle)
//   rd_op_i/wr_op_i: latched op type, selects which strobe fires in the request state
//   mem_done_i     : cache access complete (ignored in idle)
//   mem_rd_o/wr_o  : single-cycle request strobes
//   stall_o        : access outstanding, decoded from the registered state
//   cplt_o         : completion pulse (cycle in which mem_done_i ends the access)
//   timeout_o      : pulse when the access is abandoned by the timeout counter
module dc_access_fsm
   import ex_mem_pkg::*;
#(
   parameter int unsigned Timeout = DefTimeout
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic rd_op_i,
   input  logic wr_op_i,
   input  logic mem_done_i,
   output logic mem_rd_o,
   output logic mem_wr_o,
   output logic stall_o,
   output logic cplt_o,
   output logic timeout_o
);

   dc_state_e state_q, state_d;

`ifdef EX_MEM_DC_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = Timeout;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_rd_o  = 1'b0;
      mem_wr_o  = 1'b0;
      cplt_o    = 1'b0;
      timeout_o = 1'b0;
`ifdef EX_MEM_DC_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StReq;
`ifdef EX_MEM_DC_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         StReq: begin
            // The only state that drives a strobe, so each access strobes exactly once.
            mem_rd_o = rd_op_i;
            mem_wr_o = wr_op_i;
            if (mem_done_i) begin
               state_d = StIdle;
               cplt_o  = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_done_i) begin
               state_d = StIdle;
               cplt_o  = 1'b1;
            end else begin
`ifdef EX_MEM_DC_TIMEOUT_EN
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == 8'(Timeout)) begin
                  state_d   = StIdle;
                  timeout_o = 1'b1;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign stall_o = (state_q != StIdle);

endmodule

// File: rtl/ex_mem_dc.sv
// ex_mem_dc: EX/MEM pipeline register with data-cache access control.
// Build option: EX_MEM_DC_TIMEOUT_EN enables the WAIT-state timeout (limit TIMEOUT); an
// abandoned access reports err_out for that instruction and captures no load data.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   *_in                         : execute-stage results and control bits
//   mem_rdata, mem_done          : data-cache response
//   mem_addr, mem_wdata          : request address / store data (from stage registers)
//   mem_rd, mem_wr               : one-cycle request strobes
//   *_out, mem_rdata_out         : to MEM/WB
//   DC_Stall                     : access outstanding; freezes upstream, bubble to MEM/WB
module ex_mem_dc
   import ex_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WordW-1:0] ALU_result_in,
   input  logic [WordW-1:0] writeData_in,
   input  logic [2:0]       Write_register_in,
   input  logic             RegWrite_in,
   input  logic             MemRead_in,
   input  logic             MemWrite_in,
   input  logic             MemtoReg_in,
   input  logic             link_in,
   input  logic             halt_in,
   input  logic             createdump_in,
   input  logic             err_in,
   input  logic [WordW-1:0] PC_plus_two_in,
   input  logic [WordW-1:0] mem_rdata,
   input  logic             mem_done,
   output logic [WordW-1:0] mem_addr,
   output logic [WordW-1:0] mem_wdata,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [WordW-1:0] ALU_result_out,
   output logic [WordW-1:0] PC_plus_two_out,
   output logic [WordW-1:0] mem_rdata_out,
   output logic [2:0]       Write_register_out,
   output logic             RegWrite_out,
   output logic             MemtoReg_out,
   output logic             link_out,
   output logic             halt_out,
   output logic             createdump_out,
   output logic             err_out,
   output logic             DC_Stall
);

   stage_t           stage_q, stage_d;
   logic [WordW-1:0] rdata_q;
   logic             tmo_q;
   logic             stall, cplt, timeout;
   logic             mem_op_in, valid_mem_in;

   // Exactly one strobe and a halfword-aligned address; anything else is flagged, not issued.
   assign mem_op_in    = MemRead_in | MemWrite_in;
   assign valid_mem_in = (MemRead_in ^ MemWrite_in) & ~ALU_result_in[0];

   always_comb begin
      stage_d          = '0;
      stage_d.alu      = ALU_result_in;
      stage_d.wdata    = writeData_in;
      stage_d.pc2      = PC_plus_two_in;
      stage_d.wreg     = Write_register_in;
      stage_d.regw     = RegWrite_in;
      stage_d.mrd      = MemRead_in;
      stage_d.mwr      = MemWrite_in;
      stage_d.mtr      = MemtoReg_in;
      stage_d.link     = link_in;
      stage_d.halt     = halt_in;
      stage_d.dump     = createdump_in;
      stage_d.err      = err_in;
      stage_d.misalign = mem_op_in & ~valid_mem_in;
   end

   // Stage registers load only while idle; they hold the instruction during an access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
      end else if (!stall) begin
         stage_q <= stage_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (cplt && stage_q.mrd) begin
         rdata_q <= mem_rdata;
      end
   end

   // Timeout error belongs to the held instruction; cleared when the next one is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= 1'b0;
      end else if (timeout) begin
         tmo_q <= 1'b1;
      end else if (!stall) begin
         tmo_q <= 1'b0;
      end
   end

   dc_access_fsm #(
      .Timeout (TIMEOUT)
   ) u_fsm (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (valid_mem_in),
      .rd_op_i    (stage_q.mrd),
      .wr_op_i    (stage_q.mwr),
      .mem_done_i (mem_done),
      .mem_rd_o   (mem_rd),
      .mem_wr_o   (mem_wr),
      .stall_o    (stall),
      .cplt_o     (cplt),
      .timeout_o  (timeout)
   );

   assign DC_Stall           = stall;
   assign mem_addr           = stage_q.alu;
   assign mem_wdata          = stage_q.wdata;
   assign ALU_result_out     = stage_q.alu;
   assign PC_plus_two_out    = stage_q.pc2;
   assign mem_rdata_out      = rdata_q;
   assign Write_register_out = stage_q.wreg;
   assign MemtoReg_out       = stage_q.mtr;
   assign link_out           = stage_q.link;

   // Side-effecting controls are squashed so MEM/WB sees a bubble while stalled.
   assign RegWrite_out   = stage_q.regw & ~stall;
   assign halt_out       = stage_q.halt & ~stall;
   assign createdump_out = stage_q.dump & ~stall;
   assign err_out        = (stage_q.err | stage_q.misalign | tmo_q) & ~stall;

endmodule

// File: tb/tb_ex_mem_dc.sv
module tb_ex_mem_dc;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ALU_result_in, writeData_in, PC_plus_two_in, mem_rdata;
   logic [2:0]  Write_register_in;
   logic        RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in, link_in, halt_in;
   logic        createdump_in, err_in, mem_done;
   logic [15:0] mem_addr, mem_wdata, ALU_result_out, PC_plus_two_out, mem_rdata_out;
   logic [2:0]  Write_register_out;
   logic        mem_rd, mem_wr, RegWrite_out, MemtoReg_out, link_out, halt_out;
   logic        createdump_out, err_out, DC_Stall;

   always #5 clk = ~clk;

   ex_mem_dc #(
      .TIMEOUT (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .ALU_result_in      (ALU_result_in),
      .writeData_in       (writeData_in),
      .Write_register_in  (Write_register_in),
      .RegWrite_in        (RegWrite_in),
      .MemRead_in         (MemRead_in),
      .MemWrite_in        (MemWrite_in),
      .MemtoReg_in        (MemtoReg_in),
      .link_in            (link_in),
      .halt_in            (halt_in),
      .createdump_in      (createdump_in),
      .err_in             (err_in),
      .PC_plus_two_in     (PC_plus_two_in),
      .mem_rdata          (mem_rdata),
      .mem_done           (mem_done),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_rd             (mem_rd),
      .mem_wr             (mem_wr),
      .ALU_result_out     (ALU_result_out),
      .PC_plus_two_out    (PC_plus_two_out),
      .mem_rdata_out      (mem_rdata_out),
      .Write_register_out (Write_register_out),
      .RegWrite_out       (RegWrite_out),
      .MemtoReg_out       (MemtoReg_out),
      .link_out           (link_out),
      .halt_out           (halt_out),
      .createdump_out     (createdump_out),
      .err_out            (err_out),
      .DC_Stall           (DC_Stall)
   );

   typedef struct {
      logic [15:0] alu;
      logic [15:0] pc2;
      logic [2:0]  wreg;
      logic        regw;
      logic        err;
      logic [15:0] rdata;
      int          stall;
      int          rds;
      int          wrs;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [15:0] model_rdata = 16'h0000;

   // Strobe counters, sampled mid-cycle.
   always @(negedge clk) begin
      rd_cnt <= rd_cnt + (mem_rd ? 1 : 0);
      wr_cnt <= wr_cnt + (mem_wr ? 1 : 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      ALU_result_in     = 16'h0000;
      writeData_in      = 16'h0000;
      PC_plus_two_in    = 16'h0000;
      Write_register_in = 3'd0;
      RegWrite_in       = 1'b0;
      MemRead_in        = 1'b0;
      MemWrite_in       = 1'b0;
      MemtoReg_in       = 1'b0;
      link_in           = 1'b0;
      halt_in           = 1'b0;
      createdump_in     = 1'b0;
      err_in            = 1'b0;
      mem_done          = 1'b0;
      mem_rdata         = 16'hDEAD;
   endtask

   // Drive one instruction, push its expected result, drive mem_done done_after cycles
   // into the stall (negative: never), then pop and compare once the stage is idle.
   task automatic run(input string tag, input logic [15:0] alu, input logic [15:0] wd,
                      input logic [2:0] wreg, input logic regw, input logic mrd,
                      input logic mwr, input logic err, input int done_after,
                      input logic [15:0] rdata);
      exp_t e, g;
      logic valid, tmo;
      int   rd0, wr0, k;
      valid = (mrd ^ mwr) && !alu[0];
      tmo   = 1'b0;
`ifdef EX_MEM_DC_TIMEOUT_EN
      tmo   = valid && (done_after < 0);
`endif
      e.alu   = alu;
      e.pc2   = alu + 16'h0100;
      e.wreg  = wreg;
      e.regw  = regw;
      e.err   = err | ((mrd | mwr) && !valid) | tmo;
      e.stall = !valid ? 0 : (tmo ? 9 : done_after + 1);
      if (valid && mrd && !tmo) model_rdata = rdata;
      e.rdata = model_rdata;
      e.rds   = (valid && mrd) ? 1 : 0;
      e.wrs   = (valid && mwr) ? 1 : 0;
      exp_q.push_back(e);

      ALU_result_in     = alu;
      writeData_in      = wd;
      PC_plus_two_in    = alu + 16'h0100;
      Write_register_in = wreg;
      RegWrite_in       = regw;
      MemRead_in        = mrd;
      MemWrite_in       = mwr;
      MemtoReg_in       = mrd;
      err_in            = err;
      halt_in           = 1'b1;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      tick();
      nop();
      k = 0;
      while (DC_Stall && k < 40) begin
         chk({tag, ".bubble"}, {29'd0, RegWrite_out, err_out, halt_out}, 32'd0);
         if (k == 0) chk({tag, ".addr"}, {mem_addr, mem_wdata}, {alu, wd});
         mem_done  = (k == done_after);
         mem_rdata = mem_done ? rdata : 16'hDEAD;
         tick();
         k++;
      end
      nop();
      g = exp_q.pop_front();
      chk({tag, ".stall_cycles"}, k, g.stall);
      chk({tag, ".rd_strobes"}, rd_cnt - rd0, g.rds);
      chk({tag, ".wr_strobes"}, wr_cnt - wr0, g.wrs);
      chk({tag, ".alu_pc"}, {ALU_result_out, PC_plus_two_out}, {g.alu, g.pc2});
      chk({tag, ".wreg_regw_err_halt"}, {27'd0, Write_register_out, RegWrite_out, err_out, halt_out},
          {27'd0, g.wreg, g.regw, g.err, 1'b1});
      chk({tag, ".rdata_out"}, {16'd0, mem_rdata_out}, {16'd0, g.rdata});
   endtask

   initial begin
      int rd0;
      rst = 1'b1;
      nop();
      #2;
      chk("reset.ctrl", {22'd0, DC_Stall, mem_rd, mem_wr, RegWrite_out, MemtoReg_out, link_out,
                         halt_out, createdump_out, err_out, Write_register_out[0]}, 32'd0);
      chk("reset.data", {ALU_result_out, mem_rdata_out}, 32'd0);
      chk("reset.pc_addr", {PC_plus_two_out, mem_addr}, 32'd0);
      tick();
      rst = 1'b0;

      run("alu_op", 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
      run("load_hit", 16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'hBEEF);
      run("store_miss", 16'h0044, 16'hA5A5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 16'h0000);
      run("load_misalign", 16'h0041, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'h1111);
      run("both_strobes", 16'h0042, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 16'h2222);
      run("err_passthru", 16'h0007, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 0, 16'h0000);
      run("load_miss", 16'h0046, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2, 16'hCAFE);
      run("alu_after_load", 16'h0099, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000);

      // Reset in the middle of WAIT.
      ALU_result_in = 16'h0080;
      MemRead_in    = 1'b1;
      tick();
      nop();
      tick();
      chk("rst_wait.pre_stall", {31'd0, DC_Stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_wait.ctrl", {26'd0, DC_Stall, mem_rd, mem_wr, RegWrite_out, err_out, halt_out}, 32'd0);
      chk("rst_wait.data", {ALU_result_out, mem_rdata_out}, 32'd0);
      model_rdata = 16'h0000;
      #3;
      rst = 1'b0;
      rd0 = rd_cnt;
      tick();
      mem_done  = 1'b1;
      mem_rdata = 16'h5555;
      tick();
      tick();
      nop();
      chk("rst_wait.late_done", {15'd0, DC_Stall, mem_rdata_out}, 32'd0);
      chk("rst_wait.no_strobe", rd_cnt - rd0, 32'd0);

      run("alu_after_rst", 16'h0ABC, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000);

`ifdef EX_MEM_DC_TIMEOUT_EN
      run("load_timeout", 16'h0100, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, -1, 16'h0000);
      tick();
      chk("load_timeout.err_one_cycle", {31'd0, err_out}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ex_mem_dc.md
# ex_mem_dc

EX/MEM pipeline stage with data-memory access control, directly downstream of the ID/EX register. It latches execute-stage results and runs a small FSM for the one-shot request/done handshake with the data cache. While an access is outstanding it raises `DC_Stall`, which freezes ID/EX and everything upstream, and it presents a bubble to MEM/WB.

## Interface
- `TIMEOUT`, 255: WAIT-state cycle limit (used only with `EX_MEM_DC_TIMEOUT_EN`).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ALU_result_in` in 16: EX result; also the memory address.
- `writeData_in` in 16: store data.
- `Write_register_in` in 3: destination register.
- `RegWrite_in`, `MemRead_in`, `MemWrite_in`, `MemtoReg_in`, `link_in`, `halt_in`, `createdump_in`, `err_in` in 1 each: EX control bits.
- `PC_plus_two_in` in 16: link value.
- `mem_rdata` in 16: cache read data, valid with `mem_done`.
- `mem_done` in 1: access complete.
- `mem_addr`, `mem_wdata` out 16: request address and store data, from stage registers.
- `mem_rd`, `mem_wr` out 1: request strobes, one cycle wide.
- `ALU_result_out`, `PC_plus_two_out`, `mem_rdata_out` out 16: to MEM/WB.
- `Write_register_out` out 3: to MEM/WB.
- `RegWrite_out`, `MemtoReg_out`, `link_out`, `halt_out`, `createdump_out`, `err_out` out 1: to MEM/WB.
- `DC_Stall` out 1: freeze upstream stages; MEM/WB must treat the stage as a bubble.

## Operation
**States:** IDLE, REQ, WAIT.

**IDLE**
- Stage registers load all `*_in` fields on every edge.
- If the incoming instruction is a valid memory op, the next state is REQ.
- A valid memory op has exactly one of `MemRead_in`/`MemWrite_in` set and `ALU_result_in[0]==0`.

**Invalid memory ops** (both strobes set, or odd address)
- Load with an internal misalign flag; the state stays IDLE and no request is issued.
- `err_out = err_reg | misalign`.

**REQ**
- `mem_rd` or `mem_wr` = 1, per the latched op.
- If `mem_done`=1, go to IDLE; on a load, capture `mem_rdata` into `mem_rdata_out`.
- Otherwise go to WAIT.

**WAIT**
- Strobes are 0.
- Go to IDLE on `mem_done`, capturing load data as in REQ.

**Stall and bubble**
- `DC_Stall` = (state != IDLE), decoded from the registered state.
- While `DC_Stall`=1: `RegWrite_out`, `halt_out`, `createdump_out`, `err_out` are forced to 0 and the stage registers hold.
- The other outputs show the held values.

**Other rules**
- `mem_done` is ignored in IDLE.
- `mem_rdata_out` changes only on load completion.

## Timing
- **Reset:** state IDLE; all outputs and registers 0, including `DC_Stall`, `mem_rd`, `mem_wr` and `mem_rdata_out`. A reset mid-access abandons the access immediately, with no further strobe.
- **Non-memory instruction:** outputs valid in the cycle after capture; zero stall.
- **Memory op, hit** (`mem_done` in REQ): 1 stall cycle; outputs valid 2 cycles after capture.
- **Memory op, miss with `mem_done` N cycles after REQ:** N+1 stall cycles.
- **Back-to-back memory ops:** the second is captured on the edge ending the first's IDLE cycle. It never overlaps the first's request.
- The strobe is asserted exactly once per access and never while in WAIT.

## Configuration
Macro `EX_MEM_DC_TIMEOUT_EN`.
- **Defined:** an 8-bit counter clears on entry to REQ and increments each WAIT cycle.
  - When it reaches `TIMEOUT` with no `mem_done`, the next state is IDLE and a sticky timeout error ORs into `err_out` for that instruction.
  - Load data is not captured in that case.
- **Undefined:** no counter; WAIT persists until `mem_done`.

## Structure
- **Package `ex_mem_pkg`:** holds the state enum (IDLE, REQ, WAIT), the default `TIMEOUT`, and the 16-bit word-width constant.
- **Sub-module `dc_access_fsm`:** contains the state register, strobe generation, `DC_Stall`, the completion pulse and the optional timeout counter.
- **Top level:** holds the stage registers, load-data capture and bubble gating.

## Test plan
1. **ALU op:** `RegWrite_in`=1, `Write_register_in`=3, result 0x1234 → next cycle `RegWrite_out`=1, `ALU_result_out`=0x1234, `DC_Stall`=0 throughout.
2. **Load hit:** addr 0x0040, `mem_done` in REQ with `mem_rdata`=0xBEEF → `mem_rd` high 1 cycle, `DC_Stall` high 1 cycle, `mem_rdata_out`=0xBEEF next cycle, `RegWrite_out` 0 during the stall.
3. **Store miss:** `mem_done` 4 cycles after REQ → `mem_wr` pulses once, `DC_Stall` high 5 cycles, no second strobe.
4. **Misaligned load** at 0x0041 → no `mem_rd`, `DC_Stall` stays 0, `err_out`=1 next cycle.
5. **Reset in WAIT:** `rst` pulsed mid-WAIT → state IDLE, all outputs 0 asynchronously; a later `mem_done` is ignored.
6. **With `EX_MEM_DC_TIMEOUT_EN`, `TIMEOUT`=8, no `mem_done`** → IDLE after 8 WAIT cycles, `err_out`=1 for one cycle, `mem_rdata_out` unchanged.
